// File: rtl/reg_file_param.sv
// Parametrised two-read/one-write register file with optional x0 hardwiring,
// write-to-read forwarding, read stall hold and a zero-sweep clear sequencer.
module reg_file_param #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    output logic [DATA_W-1:0] datos1,
    output logic [DATA_W-1:0] datos2,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   ptr_reg;
    logic                ready_reg;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                wr_accept;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    // clr wins over a write issued in the same cycle.
    assign wr_accept = (state_reg == RUN) && !clr && write_en &&
                       !(ZERO_R0 && (write_addr == '0));

    // Single write port shared between the sweep and the writeback path.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = write_addr;
        mem_wdata = write_data;
        if (state_reg == INIT) begin
            mem_we    = 1'b1;
            mem_waddr = ptr_reg;
            mem_wdata = '0;
        end else if (wr_accept) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= INIT;
            ptr_reg   <= '0;
            ready_reg <= 1'b0;
        end else begin
            case (state_reg)
                INIT: begin
                    if (clr) begin
                        ptr_reg <= '0;
                    end else if (ptr_reg == LAST) begin
                        state_reg <= RUN;
                        ready_reg <= 1'b1;
                        ptr_reg   <= '0;
                    end else begin
                        ptr_reg <= ptr_reg + 1'b1;
                    end
                end
                RUN: begin
                    if (clr) begin
                        state_reg <= INIT;
                        ptr_reg   <= '0;
                        ready_reg <= 1'b0;
                    end
                end
                default: state_reg <= INIT;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [ADDR_W-1:0] addr;
            logic              hit;
            logic [DATA_W-1:0] rd_next;
            logic [DATA_W-1:0] datos_reg;

            assign addr = (gi == 0) ? addr1 : addr2;
            assign hit  = BYPASS && wr_accept && (write_addr == addr);

            // Zero-register override is applied last so it also masks forwarding.
            always_comb begin
                rd_next = mem[addr];
                if (hit) begin
                    rd_next = write_data;
                end
                if (ZERO_R0 && (addr == '0)) begin
                    rd_next = '0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    datos_reg <= '0;
                end else if (state_reg == RUN) begin
                    if (clr) begin
                        datos_reg <= '0;
                    end else if (rd_en) begin
                        datos_reg <= rd_next;
                    end
                end
            end
        end
    endgenerate

    assign datos1 = g_port[0].datos_reg;
    assign datos2 = g_port[1].datos_reg;
    assign ready  = ready_reg;
endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: a default instance and a 64-bit/16-entry
// instance with x0 as an ordinary register and forwarding disabled.
module tb_reg_file_param;
    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic        a_clr = 1'b0, a_rd_en = 1'b0, a_write_en = 1'b0, a_ready;
    logic [4:0]  a_addr1 = '0, a_addr2 = '0, a_write_addr = '0;
    logic [31:0] a_write_data = '0, a_datos1, a_datos2;

    logic        b_clr = 1'b0, b_rd_en = 1'b0, b_write_en = 1'b0, b_ready;
    logic [3:0]  b_addr1 = '0, b_addr2 = '0, b_write_addr = '0;
    logic [63:0] b_write_data = '0, b_datos1, b_datos2;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];
    string       tag_q[$];

    reg_file_param u_a (
        .clk(clk), .rst_n(rst_n), .clr(a_clr), .ready(a_ready), .rd_en(a_rd_en),
        .addr1(a_addr1), .addr2(a_addr2), .datos1(a_datos1), .datos2(a_datos2),
        .write_en(a_write_en), .write_addr(a_write_addr), .write_data(a_write_data)
    );

    reg_file_param #(.DATA_W(64), .ADDR_W(4), .ZERO_R0(1'b0), .BYPASS(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .clr(b_clr), .ready(b_ready), .rd_en(b_rd_en),
        .addr1(b_addr1), .addr2(b_addr2), .datos1(b_datos1), .datos2(b_datos2),
        .write_en(b_write_en), .write_addr(b_write_addr), .write_data(b_write_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [63:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic sb_pop(input logic [63:0] actual);
        string t;
        logic [63:0] e;
        if (exp_q.size() == 0) begin
            check("sb_underflow", 64'd1, 64'd0);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            check(t, actual, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_pop2();
        sb_pop(64'(a_datos1));
        sb_pop(64'(a_datos2));
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_a_ready", 64'(a_ready), 64'd0);
        check("rst_a_datos1", 64'(a_datos1), 64'd0);
        check("rst_a_datos2", 64'(a_datos2), 64'd0);
        check("rst_b_ready", 64'(b_ready), 64'd0);
        check("rst_b_datos1", b_datos1, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Init sweep with writes and reads requested but ignored.
        a_write_en = 1'b1; a_write_addr = 5'd3; a_write_data = 32'hDEAD_BEEF;
        a_rd_en = 1'b1; a_addr1 = 5'd3;
        for (int e = 1; e <= 32; e++) begin
            tick();
            check($sformatf("init_a_ready_e%0d", e), 64'(a_ready), 64'(e == 32));
            check($sformatf("init_b_ready_e%0d", e), 64'(b_ready), 64'(e >= 16));
        end
        a_write_en = 1'b0;
        a_addr1 = 5'd3; a_addr2 = 5'd0;
        sb_push("init_r3", 64'd0); sb_push("init_r0", 64'd0);
        tick(); a_pop2();

        // Basic R/W and the hardwired zero register.
        a_rd_en = 1'b0;
        a_write_en = 1'b1; a_write_addr = 5'd7; a_write_data = 32'h1234_5678;
        tick();
        a_write_en = 1'b0; a_rd_en = 1'b1; a_addr1 = 5'd7; a_addr2 = 5'd0;
        sb_push("basic_r7", 64'h1234_5678); sb_push("basic_r0", 64'd0);
        tick(); a_pop2();
        a_rd_en = 1'b0;
        a_write_en = 1'b1; a_write_addr = 5'd0; a_write_data = 32'hFFFF_FFFF;
        tick();
        a_write_en = 1'b0; a_rd_en = 1'b1; a_addr1 = 5'd0; a_addr2 = 5'd0;
        sb_push("zero_r0_p1", 64'd0); sb_push("zero_r0_p2", 64'd0);
        tick(); a_pop2();

        // Ordinary r0 on the wide instance.
        b_write_en = 1'b1; b_write_addr = 4'd0; b_write_data = 64'h0123_4567_89AB_CDEF;
        tick();
        b_write_en = 1'b0; b_rd_en = 1'b1; b_addr1 = 4'd0; b_addr2 = 4'd3;
        sb_push("b_r0", 64'h0123_4567_89AB_CDEF); sb_push("b_r3", 64'd0);
        tick(); sb_pop(b_datos1); sb_pop(b_datos2);

        // Forwarding: bypass on a, old data on b.
        a_rd_en = 1'b0;
        a_write_en = 1'b1; a_write_addr = 5'd5; a_write_data = 32'hAAAA_AAAA;
        b_rd_en = 1'b0;
        b_write_en = 1'b1; b_write_addr = 4'd5; b_write_data = 64'hAAAA_AAAA_AAAA_AAAA;
        tick();
        a_write_data = 32'h5555_5555; a_rd_en = 1'b1; a_addr1 = 5'd5; a_addr2 = 5'd5;
        b_write_data = 64'h5555_5555_5555_5555; b_rd_en = 1'b1; b_addr1 = 4'd5; b_addr2 = 4'd5;
        sb_push("fwd_a_p1", 64'h5555_5555); sb_push("fwd_a_p2", 64'h5555_5555);
        sb_push("nofwd_b_p1", 64'hAAAA_AAAA_AAAA_AAAA); sb_push("nofwd_b_p2", 64'hAAAA_AAAA_AAAA_AAAA);
        tick(); a_pop2(); sb_pop(b_datos1); sb_pop(b_datos2);
        a_write_en = 1'b0; b_write_en = 1'b0;
        sb_push("reread_b_p1", 64'h5555_5555_5555_5555); sb_push("reread_b_p2", 64'h5555_5555_5555_5555);
        tick(); sb_pop(b_datos1); sb_pop(b_datos2);

        // Stall hold.
        a_rd_en = 1'b0;
        a_write_en = 1'b1; a_write_addr = 5'd2; a_write_data = 32'h1111_1111;
        tick();
        a_write_en = 1'b0; a_rd_en = 1'b1; a_addr1 = 5'd2; a_addr2 = 5'd7;
        sb_push("stall_pre_p1", 64'h1111_1111); sb_push("stall_pre_p2", 64'h1234_5678);
        tick(); a_pop2();
        a_rd_en = 1'b0; a_addr1 = 5'd4; a_addr2 = 5'd5;
        a_write_en = 1'b1; a_write_addr = 5'd2; a_write_data = 32'h2222_2222;
        sb_push("stall_hold1_p1", 64'h1111_1111); sb_push("stall_hold1_p2", 64'h1234_5678);
        tick(); a_pop2();
        a_write_en = 1'b0;
        sb_push("stall_hold2_p1", 64'h1111_1111); sb_push("stall_hold2_p2", 64'h1234_5678);
        tick(); a_pop2();
        a_rd_en = 1'b1; a_addr1 = 5'd2; a_addr2 = 5'd4;
        sb_push("stall_rel_p1", 64'h2222_2222); sb_push("stall_rel_p2", 64'd0);
        tick(); a_pop2();

        // clr colliding with a write.
        a_rd_en = 1'b0; a_write_en = 1'b1;
        for (int i = 1; i < 32; i++) begin
            a_write_addr = 5'(i); a_write_data = 32'hC000_0000 + 32'(i);
            tick();
        end
        a_write_en = 1'b0; a_rd_en = 1'b1; a_addr1 = 5'd31; a_addr2 = 5'd9;
        sb_push("fill_r31", 64'hC000_001F); sb_push("fill_r9", 64'hC000_0009);
        tick(); a_pop2();
        a_clr = 1'b1; a_write_en = 1'b1; a_write_addr = 5'd9; a_write_data = 32'h99;
        a_addr1 = 5'd9; a_addr2 = 5'd31;
        sb_push("clr_datos1", 64'd0); sb_push("clr_datos2", 64'd0);
        tick(); a_pop2();
        check("clr_ready", 64'(a_ready), 64'd0);
        a_clr = 1'b0; a_write_en = 1'b0;
        for (int e = 1; e <= 32; e++) begin
            tick();
            if (e >= 31) check($sformatf("clr_sweep_ready_e%0d", e), 64'(a_ready), 64'(e == 32));
        end
        for (int i = 0; i < 16; i++) begin
            a_addr1 = 5'(2 * i); a_addr2 = 5'(2 * i + 1);
            sb_push($sformatf("cleared_r%0d", 2 * i), 64'd0);
            sb_push($sformatf("cleared_r%0d", 2 * i + 1), 64'd0);
            tick(); a_pop2();
        end

        // Async reset mid-RUN, then mid-sweep.
        a_rd_en = 1'b0; a_write_en = 1'b1; a_write_addr = 5'd3; a_write_data = 32'h3333_3333;
        tick();
        a_write_en = 1'b0; a_rd_en = 1'b1; a_addr1 = 5'd3; a_addr2 = 5'd3;
        sb_push("pre_rst_p1", 64'h3333_3333); sb_push("pre_rst_p2", 64'h3333_3333);
        tick(); a_pop2();
        #2 rst_n = 1'b0;
        #1;
        check("run_rst_a_ready", 64'(a_ready), 64'd0);
        check("run_rst_a_datos1", 64'(a_datos1), 64'd0);
        check("run_rst_a_datos2", 64'(a_datos2), 64'd0);
        check("run_rst_b_ready", 64'(b_ready), 64'd0);
        check("run_rst_b_datos1", b_datos1, 64'd0);
        tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 10; e++) tick();
        #2 rst_n = 1'b0;
        #1;
        check("sweep_rst_a_ready", 64'(a_ready), 64'd0);
        check("sweep_rst_a_datos1", 64'(a_datos1), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            tick();
            if (e >= 15) begin
                check($sformatf("resweep_a_ready_e%0d", e), 64'(a_ready), 64'(e == 32));
                check($sformatf("resweep_b_ready_e%0d", e), 64'(b_ready), 64'(e >= 16));
            end
        end

        // 64-bit round trip after the re-sweep.
        b_rd_en = 1'b0; b_write_en = 1'b1; b_write_addr = 4'd15; b_write_data = 64'hFEDC_BA98_7654_3210;
        tick();
        b_write_en = 1'b0; b_rd_en = 1'b1; b_addr1 = 4'd15; b_addr2 = 4'd0;
        sb_push("b_r15", 64'hFEDC_BA98_7654_3210); sb_push("b_r0_cleared", 64'd0);
        tick(); sb_pop(b_datos1); sb_pop(b_datos2);

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised successor to the 32x32 two-read/one-write register file in the RV32I datapath.
- Generalises data width and depth, and makes x0 hardwiring and write-to-read forwarding selectable.
- Adds a read-enable stall hold, an asynchronous active-low reset, and a hardware clear sequencer that sweeps zeros through the array after reset or on request.
- Sits between decode (read addresses) and writeback (write port) of the core pipeline.

Parameters:
- DATA_W, 32, width of each register and of each data port.
- ADDR_W, 5, address width; depth DEPTH = 2**ADDR_W (derived localparam, not overridable).
- ZERO_R0, 1, 1: entry 0 reads as 0 and writes to it are dropped; 0: entry 0 is an ordinary register.
- BYPASS, 1, 1: a same-cycle write to a read address is forwarded (read returns new data); 0: read returns old data.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  request to re-zero the whole array; sampled on clk.
- ready  out  1  1 = array initialised; reads and writes are accepted.
- rd_en  in  1  read enable; 0 holds datos1/datos2.
- addr1  in  ADDR_W  read port 1 address.
- addr2  in  ADDR_W  read port 2 address.
- datos1  out  DATA_W  read port 1 data, registered.
- datos2  out  DATA_W  read port 2 data, registered.
- write_en  in  1  write enable.
- write_addr  in  ADDR_W  write address.
- write_data  in  DATA_W  write data.

Behaviour:
- One clock; reset is asynchronous and active-low: clk, rst_n.
- Reset (rst_n=0, immediate, no clock needed):
  - state=INIT, sweep pointer=0, ready=0, datos1=0, datos2=0.
  - Array contents are not reset directly; they are cleared by the sweep.
- State machine has two states, INIT and RUN.
- INIT:
  - Each rising edge writes 0 to entry[ptr] and increments ptr.
  - The edge that writes entry DEPTH-1 moves to RUN and sets ready=1.
  - ready therefore rises after the DEPTH-th rising edge with rst_n high: edge 32 for defaults.
  - write_en and rd_en are ignored; datos1/datos2 hold 0.
  - clr in INIT restarts the sweep (ptr=0).
- RUN, write:
  - When write_en=1, entry[write_addr] <= write_data at the edge.
  - Dropped if ZERO_R0=1 and write_addr=0.
  - Writes are independent of rd_en.
- RUN, read:
  - When rd_en=1, datos1/datos2 are updated at the edge (1-cycle latency) from addr1/addr2.
  - When rd_en=0, both outputs hold their previous values.
- Zero register: if ZERO_R0=1, a read of address 0 returns 0 regardless of array contents or a forwarded write.
- Read/write collision (rd_en=1, write_en=1, write_addr==addrN, write not dropped):
  - BYPASS=1: datosN <= write_data.
  - BYPASS=0: datosN <= previous contents.
  - Both ports may hit the same write in the same cycle; each port forwards independently.
- clr in RUN:
  - Next edge: state=INIT, ptr=0, ready=0.
  - Any write_en in that cycle is discarded; clr has priority.
  - datos1/datos2 are forced to 0 on that edge.
- Reset mid-sweep or mid-RUN: immediate return to the reset values above; the sweep restarts from 0 after release.
- Address arithmetic: ptr is ADDR_W+0 bits with no wrap; the terminal compare is ptr==DEPTH-1.
- Address inputs are always in range: there is no out-of-range case.

Test Plan:
- Init sweep: release rst_n, hold write_en=1 (write_addr=3, write_data=0xDEAD_BEEF) → ready=0 for edges 1..31, ready=1 after edge 32; then read addr1=3 → datos1=0 (the write was ignored during INIT).
- Basic R/W: RUN, write 0x1234_5678 to r7, next cycle rd_en=1 with addr1=7, addr2=0 → datos1=0x1234_5678 one edge later, datos2=0. Then write 0xFFFF_FFFF to r0 and read r0 → 0.
- Forwarding: r5=0xAAAA_AAAA, same cycle write r5=0x5555_5555 with addr1=addr2=5, rd_en=1 → BYPASS=1: both outputs 0x5555_5555; BYPASS=0 build: both 0xAAAA_AAAA, and a re-read gives 0x5555_5555.
- Stall hold: datos1=0x1111_1111, rd_en=0, change addr1 and write to the old address → datos1 stays 0x1111_1111 until rd_en=1.
- clr collision: fill r1..r31 with nonzero values, assert clr together with write_en (r9=0x99) → ready=0 next edge, datos outputs=0; after 32 edges ready=1 and all registers read 0, including r9.
- Async reset mid-sweep: deassert rst_n at sweep edge 10, between clock edges → ready, datos1 and datos2 drop to 0 immediately; after release, ready rises exactly 32 edges later. Repeat with DATA_W=64, ADDR_W=4 (ready after 16 edges, 64-bit data round-trips).
